// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the memory arbiter: FSM and owner encodings, parameter
// defaults and the timeout counter width helper.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_DM = 1'b1
  } owner_t;

  localparam int unsigned DEF_TIMEOUT  = 255;
  localparam logic [31:0] DEF_ERR_DATA = 32'h0000_0000;
  localparam logic [3:0]  FETCH_BE     = 4'hF;

  // Width needed to hold counts up to the timeout limit.
  function automatic int unsigned cnt_width(input int unsigned limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arbiter_bus_timeout_counter.sv
// Saturating cycle counter for the bus timeout: cleared when a transaction
// starts, counts while enabled, flags the final permitted cycle.
module bus_timeout_counter #(
  parameter int unsigned LIMIT = 255,
  parameter int unsigned W     = 8
) (
  input  logic clk,
  input  logic resetn,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_tc
);

  localparam logic [W-1:0] LAST = W'(LIMIT - 1);

  logic [W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable && (r_count != LAST)) begin
      r_count <= r_count + 1'b1;
    end
  end

  // Asserted during the LIMIT-th enabled cycle since the last clear.
  assign o_tc = i_enable && (r_count == LAST);

endmodule

// File: rtl/mem_arbiter.sv
// Arbiter sharing one single-port memory between instruction fetch and data
// access; one transaction in flight, data side wins ties, bus timeout recovery.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned TIMEOUT  = DEF_TIMEOUT,
  parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_cancel,
  output logic        if_ack,
  output logic [31:0] if_rdata,
  input  logic        dm_req,
  input  logic        dm_we,
  input  logic [3:0]  dm_be,
  input  logic [31:0] dm_addr,
  input  logic [31:0] dm_wdata,
  output logic        dm_ack,
  output logic [31:0] dm_rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        stallF,
  output logic        stallM,
  output logic        bus_err
);

  localparam int unsigned CW = cnt_width(TIMEOUT);

  state_t      r_state, w_state_next;
  owner_t      r_owner;
  logic        r_mem_req, r_mem_we;
  logic [3:0]  r_mem_be;
  logic [31:0] r_mem_addr, r_mem_wdata;
  logic [31:0] r_if_rdata, r_dm_rdata;
  logic        r_bus_err, r_cancel;

  logic        w_latch_dm, w_latch_if, w_capture, w_timeout;
  logic        w_tc, w_busy, w_cancel_now;
  logic [31:0] w_resp_data;

  assign w_busy       = (r_state == ST_REQ) || (r_state == ST_RESP);
  // A cancel seen this cycle must already suppress capture and ack.
  assign w_cancel_now = r_cancel ||
                        (if_cancel && (r_owner == OWN_IF) && (r_state != ST_IDLE));
  assign w_resp_data  = w_capture ? mem_rdata : ERR_DATA;

  bus_timeout_counter #(
    .LIMIT (TIMEOUT),
    .W     (CW)
  ) u_timeout (
    .clk      (clk),
    .resetn   (resetn),
    .i_clear  (w_latch_dm || w_latch_if),
    .i_enable (w_busy),
    .o_tc     (w_tc)
  );

  always_comb begin
    w_state_next = r_state;
    w_latch_dm   = 1'b0;
    w_latch_if   = 1'b0;
    w_capture    = 1'b0;
    w_timeout    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dm_req) begin
          w_latch_dm   = 1'b1;
          w_state_next = ST_REQ;
        end else if (if_req && !if_cancel) begin
          w_latch_if   = 1'b1;
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (w_tc) begin
          w_timeout    = 1'b1;
          w_state_next = ST_DONE;
        end else if (mem_gnt) begin
          w_state_next = ST_RESP;
        end
      end
      ST_RESP: begin
        // Real data arriving on the last permitted cycle beats the timeout.
        if (mem_rvalid) begin
          w_capture    = 1'b1;
          w_state_next = ST_DONE;
        end else if (w_tc) begin
          w_timeout    = 1'b1;
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWN_IF;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_be    <= 4'h0;
      r_mem_addr  <= 32'h0;
      r_mem_wdata <= 32'h0;
      r_if_rdata  <= 32'h0;
      r_dm_rdata  <= 32'h0;
      r_bus_err   <= 1'b0;
      r_cancel    <= 1'b0;
    end else begin
      r_state   <= w_state_next;
      r_mem_req <= (w_state_next == ST_REQ);
      if (w_latch_dm) begin
        r_owner     <= OWN_DM;
        r_mem_we    <= dm_we;
        r_mem_be    <= dm_be;
        r_mem_addr  <= dm_addr;
        r_mem_wdata <= dm_wdata;
      end else if (w_latch_if) begin
        r_owner     <= OWN_IF;
        r_mem_we    <= 1'b0;
        r_mem_be    <= FETCH_BE;
        r_mem_addr  <= if_addr;
        r_mem_wdata <= 32'h0;
      end
      if (w_latch_dm || w_latch_if) begin
        r_cancel <= 1'b0;
      end else if (w_cancel_now) begin
        r_cancel <= 1'b1;
      end
      if (w_capture || w_timeout) begin
        if (r_owner == OWN_DM) begin
          r_dm_rdata <= w_resp_data;
        end else if (!w_cancel_now) begin
          r_if_rdata <= w_resp_data;
        end
      end
      if (w_timeout) begin
        r_bus_err <= 1'b1;
      end
    end
  end

  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_be    = r_mem_be;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign if_rdata  = r_if_rdata;
  assign dm_rdata  = r_dm_rdata;
  assign bus_err   = r_bus_err;
  assign dm_ack    = (r_state == ST_DONE) && (r_owner == OWN_DM);
  assign if_ack    = (r_state == ST_DONE) && (r_owner == OWN_IF) && !w_cancel_now;
  assign stallF    = if_req & ~if_ack;
  assign stallM    = dm_req & ~dm_ack;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: requester drivers push expected responses,
// a monitor pops them on each ack, and a memory model answers the bus.
module tb_mem_arbiter;

  localparam int unsigned TO_VAL  = 8;
  localparam logic [31:0] ERR_VAL = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        if_req = 1'b0, if_cancel = 1'b0;
  logic [31:0] if_addr = 32'h0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        dm_req = 1'b0, dm_we = 1'b0;
  logic [3:0]  dm_be = 4'h0;
  logic [31:0] dm_addr = 32'h0, dm_wdata = 32'h0;
  logic        dm_ack;
  logic [31:0] dm_rdata;
  logic        mem_req, mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr, mem_wdata;
  logic        mem_gnt = 1'b0, mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = 32'h0;
  logic        stallF, stallM, bus_err;

  mem_arbiter #(.TIMEOUT(TO_VAL), .ERR_DATA(ERR_VAL)) dut (
    .clk(clk), .resetn(resetn),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_ack(if_ack), .if_rdata(if_rdata),
    .dm_req(dm_req), .dm_we(dm_we), .dm_be(dm_be), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .stallF(stallF), .stallM(stallM), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
  } bus_rec_t;

  int          n_checks = 0, n_pass = 0;
  logic [31:0] dm_q[$], if_q[$];
  bus_rec_t    log_q[$];
  logic [31:0] ref_mem[logic [29:0]];
  logic [31:0] slv_mem[logic [29:0]];
  int          gnt_delay = 0, rv_delay = 0;
  bit          slave_en = 1'b1;
  logic [31:0] last_if_data = 32'h0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int b = 0; b < 4; b++) if (be[b]) r[8*b +: 8] = wd[8*b +: 8];
    return r;
  endfunction

  function automatic logic [31:0] ref_get(input logic [31:0] a);
    if (ref_mem.exists(a[31:2])) return ref_mem[a[31:2]];
    return init_word(a);
  endfunction

  function automatic logic [31:0] slv_get(input logic [31:0] a);
    if (slv_mem.exists(a[31:2])) return slv_mem[a[31:2]];
    return init_word(a);
  endfunction

  // Memory model: grants after gnt_delay cycles, responds rv_delay cycles later.
  initial begin
    bus_rec_t    rec;
    logic [31:0] w;
    forever begin
      @(negedge clk);
      mem_gnt    = 1'b0;
      mem_rvalid = 1'b0;
      if (resetn && slave_en && mem_req) begin
        rec = '{we: mem_we, be: mem_be, addr: mem_addr};
        log_q.push_back(rec);
        for (int k = 0; k < gnt_delay; k++) begin
          @(negedge clk);
          check("mem_req_hold", {31'b0, mem_req}, 32'd1);
          check("mem_addr_hold", mem_addr, rec.addr);
        end
        mem_gnt = 1'b1;
        @(negedge clk);
        mem_gnt = 1'b0;
        for (int k = 0; k < rv_delay; k++) @(negedge clk);
        w = slv_get(rec.addr);
        if (rec.we) begin
          w = merge(w, mem_wdata, rec.be);
          slv_mem[rec.addr[31:2]] = w;
        end
        mem_rdata  = w;
        mem_rvalid = 1'b1;
      end
    end
  end

  // Monitor: every ack pops and checks one expected response.
  initial begin
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (dm_ack) begin
        if (dm_q.size() == 0) begin
          n_checks++;
          $display("FAIL dm_ack_unexpected: got ack with rdata %h, required no ack", dm_rdata);
        end else begin
          e = dm_q.pop_front();
          check("dm_rdata", dm_rdata, e);
        end
      end
      if (if_ack) begin
        if (if_q.size() == 0) begin
          n_checks++;
          $display("FAIL if_ack_unexpected: got ack with rdata %h, required no ack", if_rdata);
        end else begin
          e = if_q.pop_front();
          check("if_rdata", if_rdata, e);
        end
      end
    end
  end

  task automatic dm_issue(input logic we, input logic [3:0] be, input logic [31:0] addr,
                          input logic [31:0] wd, input bit exp_err,
                          output int lat, output int nreq);
    logic [31:0] exp;
    if (exp_err) exp = ERR_VAL;
    else if (we) begin
      exp = merge(ref_get(addr), wd, be);
      ref_mem[addr[31:2]] = exp;
    end else exp = ref_get(addr);
    dm_q.push_back(exp);
    dm_req = 1'b1; dm_we = we; dm_be = be; dm_addr = addr; dm_wdata = wd;
    lat = 0; nreq = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_req) nreq++;
      if (lat == 1) check("stallM_wait", {31'b0, stallM}, 32'd1);
    end while (!dm_ack && lat < 40);
    check("dm_ack_seen", {31'b0, dm_ack}, 32'd1);
    check("stallM_at_ack", {31'b0, stallM}, 32'd0);
    $display("txn dm we=%0d be=%h addr=%h wdata=%h exp=%h lat=%0d", we, be, addr, wd, exp, lat);
    dm_req = 1'b0; dm_we = 1'b0; dm_be = 4'h0; dm_addr = 32'h0; dm_wdata = 32'h0;
  endtask

  task automatic if_issue(input logic [31:0] addr, output int lat, output int nreq);
    logic [31:0] exp;
    exp = ref_get(addr);
    if_q.push_back(exp);
    if_req = 1'b1; if_addr = addr;
    lat = 0; nreq = 0;
    do begin
      @(negedge clk);
      lat++;
      if (mem_req) nreq++;
      if (lat == 1) check("stallF_wait", {31'b0, stallF}, 32'd1);
    end while (!if_ack && lat < 40);
    check("if_ack_seen", {31'b0, if_ack}, 32'd1);
    check("stallF_at_ack", {31'b0, stallF}, 32'd0);
    last_if_data = exp;
    $display("txn if addr=%h exp=%h lat=%0d", addr, exp, lat);
    if_req = 1'b0; if_addr = 32'h0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_mem_req"}, {31'b0, mem_req}, 32'd0);
    check({tag, "_mem_we"}, {31'b0, mem_we}, 32'd0);
    check({tag, "_mem_be"}, {28'b0, mem_be}, 32'd0);
    check({tag, "_mem_addr"}, mem_addr, 32'd0);
    check({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    check({tag, "_acks"}, {30'b0, if_ack, dm_ack}, 32'd0);
    check({tag, "_if_rdata"}, if_rdata, 32'd0);
    check({tag, "_dm_rdata"}, dm_rdata, 32'd0);
    check({tag, "_bus_err"}, {31'b0, bus_err}, 32'd0);
  endtask

  initial begin
    int lat, nreq, lat2, nreq2, cnt, gap;
    logic [31:0] a;
    logic        we;

    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    check("stalls_reset", {30'b0, stallF, stallM}, 32'd0);
    resetn = 1'b1;
    @(negedge clk);

    // Single load at minimum latency.
    ref_mem[30'h40] = 32'hCAFE_F00D;
    slv_mem[30'h40] = 32'hCAFE_F00D;
    dm_issue(1'b0, 4'hF, 32'h100, 32'h0, 1'b0, lat, nreq);
    check("load_latency", lat, 32'd3);
    check("load_mem_req_cycles", nreq, 32'd1);
    @(negedge clk);

    // Store and fetch together: store must go first, fetch after DONE + IDLE.
    log_q.delete();
    fork
      dm_issue(1'b1, 4'b0011, 32'h200, 32'h1234_ABCD, 1'b0, lat, nreq);
      if_issue(32'h0, lat2, nreq2);
    join
    check("tie_dm_latency", lat, 32'd3);
    check("tie_if_latency", lat2, 32'd7);
    check("tie_log_size", log_q.size(), 32'd2);
    if (log_q.size() == 2) begin
      check("tie_first", {log_q[0].we, log_q[0].be, log_q[0].addr[26:0]}, {1'b1, 4'b0011, 27'h200});
      check("tie_second", {log_q[1].we, log_q[1].be, log_q[1].addr[26:0]}, {1'b0, 4'hF, 27'h0});
    end
    @(negedge clk);

    // Grant held off five cycles.
    gnt_delay = 5;
    dm_issue(1'b0, 4'hF, 32'h204, 32'h0, 1'b0, lat, nreq);
    check("gnt_wait_latency", lat, 32'd8);
    check("gnt_wait_mem_req_cycles", nreq, 32'd6);
    gnt_delay = 0;
    @(negedge clk);

    // Fetch cancelled while waiting for the response.
    rv_delay = 2;
    if_req = 1'b1; if_addr = 32'h24;
    @(negedge clk);
    @(negedge clk);
    if_cancel = 1'b1; if_req = 1'b0; if_addr = 32'h0;
    @(negedge clk);
    if_cancel = 1'b0;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (if_ack) cnt++;
    end
    check("cancel_no_ack", cnt, 32'd0);
    check("cancel_rdata_kept", if_rdata, last_if_data);
    rv_delay = 0;
    if_issue(32'h28, lat, nreq);
    check("after_cancel_latency", lat, 32'd3);

    // Randomized mix of loads, stores and fetches.
    gap = 1;
    for (int t = 0; t < 40; t++) begin
      repeat (gap) @(negedge clk);
      gnt_delay = $urandom_range(0, 4);
      rv_delay  = $urandom_range(0, 2);
      a = 32'($urandom_range(0, 15)) << 2;
      if ($urandom_range(0, 1) == 1) begin
        we = 1'($urandom_range(0, 1));
        dm_issue(we, 4'($urandom_range(0, 15)), a, $urandom, 1'b0, lat, nreq);
      end else begin
        if_issue(a, lat, nreq);
      end
      check("rand_latency", lat, 32'(gnt_delay + rv_delay + 3 + ((gap == 0) ? 1 : 0)));
      gap = $urandom_range(0, 2);
    end
    gnt_delay = 0; rv_delay = 0;
    @(negedge clk);
    check("bus_err_clear", {31'b0, bus_err}, 32'd0);

    // No grant at all: forced completion with error data.
    slave_en = 1'b0;
    dm_issue(1'b0, 4'hF, 32'h300, 32'h0, 1'b1, lat, nreq);
    check("timeout_latency", lat, 32'(TO_VAL + 1));
    check("timeout_mem_req_cycles", nreq, 32'(TO_VAL));
    slave_en = 1'b1;
    @(negedge clk);
    check("bus_err_set", {31'b0, bus_err}, 32'd1);
    dm_issue(1'b0, 4'hF, 32'h304, 32'h0, 1'b0, lat, nreq);
    check("bus_err_sticky", {31'b0, bus_err}, 32'd1);
    @(negedge clk);

    // Reset during RESP abandons the transaction; the late response is ignored.
    rv_delay = 3;
    dm_req = 1'b1; dm_addr = 32'h108; dm_be = 4'hF;
    @(negedge clk);
    @(negedge clk);
    resetn = 1'b0; dm_req = 1'b0; dm_addr = 32'h0; dm_be = 4'h0;
    @(negedge clk);
    check_reset_outputs("midreset");
    resetn = 1'b1;
    cnt = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (dm_ack) cnt++;
    end
    check("midreset_no_ack", cnt, 32'd0);
    rv_delay = 0;
    dm_issue(1'b0, 4'hF, 32'h108, 32'h0, 1'b0, lat, nreq);
    check("recover_latency", lat, 32'd3);
    @(negedge clk);
    check("queues_drained", dm_q.size() + if_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no completion, required finish before time limit");
    $fatal(1);
  end

endmodule
